ahb_bram_ctrl: RTL and testbench

AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

---
 rtl/ahb_bram_pkg.sv | 29 ++
 rtl/ahb_bram_if.sv | 23 ++
 rtl/ahb_bram_wbuf.sv | 61 ++++++
 rtl/ahb_bram_ctrl.sv | 104 ++++++++++
 tb/tb_ahb_bram_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bram_pkg.sv
// Shared AHB-Lite codes and byte-strobe helpers for the AHB block-RAM controller.
package ahb_bram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {ERR_IDLE, ERR_STALL, ERR_RESP} err_state_e;

  // Sizes above a word fall through to a full-word strobe.
  function automatic logic [3:0] strb_gen(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: strb_gen = 4'b0001 << addr;
      HSIZE_HALF: strb_gen = 4'b0011 << {addr[1], 1'b0};
      default:    strb_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
    misaligned = ((size == HSIZE_HALF) && addr[0]) ||
                 ((size == HSIZE_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_bram_if.sv
// AHB-Lite bus bundle between a master and the block-RAM controller.
interface ahb_bram_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_bram_wbuf.sv
// One-entry write buffer: direct writes, deferred commits and read-data forwarding.
module ahb_bram_wbuf #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_vld_p1,
  input  logic                  i_rd_vld_p1,
  input  logic                  i_rd_acc,
  input  logic [ADDR_WIDTH-1:0] i_addr_p1,
  input  logic [3:0]            i_strb_p1,
  input  logic [31:0]           i_wdata,
  input  logic [31:0]           i_bram_rdata,
  output logic                  o_wr_act,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [3:0]            o_we,
  output logic [31:0]           o_wdata,
  output logic [31:0]           o_rdata
);

  logic                  r_buf_valid;
  logic [ADDR_WIDTH-1:0] r_buf_addr;
  logic [3:0]            r_buf_strb;
  logic [31:0]           r_buf_data;
  logic                  w_load, w_direct, w_commit, w_hit;

  // A read address phase owns the RAM port, so a coinciding write data phase parks here.
  assign w_load   = i_wr_vld_p1 && i_rd_acc;
  assign w_direct = i_wr_vld_p1 && !i_rd_acc;
  assign w_commit = r_buf_valid && !i_rd_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_buf_valid <= 1'b0;
    else if (w_load)   r_buf_valid <= 1'b1;
    else if (w_commit) r_buf_valid <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_buf_addr <= i_addr_p1;
      r_buf_strb <= i_strb_p1;
      r_buf_data <= i_wdata;
    end
  end

  assign o_wr_act  = w_commit || w_direct;
  assign o_wr_addr = w_commit ? r_buf_addr : i_addr_p1;
  assign o_wdata   = w_commit ? r_buf_data : i_wdata;
  assign o_we      = w_commit ? r_buf_strb : (w_direct ? i_strb_p1 : 4'b0000);

  // The RAM has not seen the buffered bytes yet, so overlay them on a matching read.
  assign w_hit = i_rd_vld_p1 && r_buf_valid && (r_buf_addr == i_addr_p1);

  always_comb begin
    o_rdata = i_bram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (w_hit && r_buf_strb[i]) o_rdata[8*i +: 8] = r_buf_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave for a registered 32-bit block RAM, zero wait states.
// Define AHB_BRAM_ERR_EN to answer misaligned or oversized transfers with a two-cycle ERROR.
module ahb_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_bram_if.slave             ahb,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wdata,
  output logic [3:0]            bram_we,
  input  logic [31:0]           bram_rdata
);

  logic                  w_acc, w_err, w_acc_ok, w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_haddr_w;
  logic                  r_rd_vld_p1, r_wr_vld_p1;
  logic [ADDR_WIDTH-1:0] r_addr_p1;
  logic [3:0]            r_strb_p1;
  logic                  w_wr_act;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_unused;

  assign w_acc     = ahb.HSEL && ahb.HREADY && !(ahb.HTRANS inside {HTRANS_IDLE, HTRANS_BUSY});
  assign w_haddr_w = ahb.HADDR[ADDR_WIDTH+1:2];
  assign w_unused  = ^ahb.HADDR[31:ADDR_WIDTH+2];

`ifdef AHB_BRAM_ERR_EN
  err_state_e r_err_st, w_err_nxt;

  assign w_err = w_acc && ((ahb.HSIZE > HSIZE_WORD) || misaligned(ahb.HSIZE, ahb.HADDR[1:0]));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_err_st <= ERR_IDLE;
    else        r_err_st <= w_err_nxt;
  end

  always_comb begin
    w_err_nxt     = r_err_st;
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    case (r_err_st)
      ERR_IDLE:  if (w_err) w_err_nxt = ERR_STALL;
      ERR_STALL: begin
        ahb.HREADYOUT = 1'b0;
        ahb.HRESP     = 1'b1;
        w_err_nxt     = ERR_RESP;
      end
      ERR_RESP: begin
        ahb.HRESP = 1'b1;
        w_err_nxt = w_err ? ERR_STALL : ERR_IDLE;
      end
      default:   w_err_nxt = ERR_IDLE;
    endcase
  end
`else
  assign w_err         = 1'b0;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
`endif

  assign w_acc_ok = w_acc && !w_err;
  assign w_rd_acc = w_acc_ok && !ahb.HWRITE;

  // Address phase -> data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rd_vld_p1 <= 1'b0;
      r_wr_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd_acc;
      r_wr_vld_p1 <= w_acc_ok && ahb.HWRITE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_acc_ok) begin
      r_addr_p1 <= w_haddr_w;
      r_strb_p1 <= strb_gen(ahb.HSIZE, ahb.HADDR[1:0]);
    end
  end

  ahb_bram_wbuf #(.ADDR_WIDTH(ADDR_WIDTH)) u_wbuf (
    .i_clk        (HCLK),
    .i_rst        (HRESET),
    .i_wr_vld_p1  (r_wr_vld_p1),
    .i_rd_vld_p1  (r_rd_vld_p1),
    .i_rd_acc     (w_rd_acc),
    .i_addr_p1    (r_addr_p1),
    .i_strb_p1    (r_strb_p1),
    .i_wdata      (ahb.HWDATA),
    .i_bram_rdata (bram_rdata),
    .o_wr_act     (w_wr_act),
    .o_wr_addr    (w_wr_addr),
    .o_we         (bram_we),
    .o_wdata      (bram_wdata),
    .o_rdata      (ahb.HRDATA)
  );

  assign bram_addr = w_rd_acc ? w_haddr_w : (w_wr_act ? w_wr_addr : w_haddr_w);

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a registered RAM model; honours AHB_BRAM_ERR_EN.
module tb_ahb_bram_ctrl;
  import ahb_bram_pkg::*;

  localparam int AW = 14;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata;
  logic [3:0]    bram_we;
  logic [31:0]   mem [0:(1<<AW)-1];
  int            checks = 0;
  int            failures = 0;

  ahb_bram_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .ahb        (bus),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_we    (bram_we),
    .bram_rdata (bram_rdata)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    bram_rdata <= mem[bram_addr];
    for (int i = 0; i < 4; i++)
      if (bram_we[i]) mem[bram_addr][8*i +: 8] = bram_wdata[8*i +: 8];
  end

  // A write data phase must never meet an occupied buffer.
  always @(negedge HCLK) begin
    if (HRESET === 1'b0) begin
      checks++;
      assert (!(dut.r_wr_vld_p1 && dut.u_wbuf.r_buf_valid)) else begin
        failures++;
        $error("FAIL wr_dphase_buf_busy observed=1 expected=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    bus.HWDATA = wd;
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    drv(1'b1, HTRANS_NONSEQ, 1'b1, a, sz, wd);
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] wd);
    drv(1'b1, HTRANS_NONSEQ, 1'b0, a, HSIZE_WORD, wd);
  endtask

  task automatic idle(input logic [31:0] wd);
    drv(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, wd);
  endtask

  task automatic at_mid;
    @(negedge HCLK);
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    HRESET = 1'b1;
    idle(32'h0);
    at_mid;
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk("rst_hresp",     32'(bus.HRESP),     32'h0);
    chk("rst_we",        32'(bram_we),       32'h0);
    chk("rst_buf_valid", 32'(dut.u_wbuf.r_buf_valid), 32'h0);
    step;
    HRESET = 1'b0;
    step;

    // Word write then readback
    wr_a(32'h10, HSIZE_WORD, 32'h0); at_mid;
    chk("w1_aphase_we", 32'(bram_we), 32'h0); step;
    idle(32'hDEADBEEF); at_mid;
    chk("w1_we", 32'(bram_we), 32'hF);
    chk("w1_addr", 32'(bram_addr), 32'h4);
    chk("w1_wdata", bram_wdata, 32'hDEADBEEF); step;
    rd_a(32'h10, 32'h0); at_mid;
    chk("r1_addr", 32'(bram_addr), 32'h4);
    chk("r1_ready_a", 32'(bus.HREADYOUT), 32'h1); step;
    idle(32'h0); at_mid;
    chk("r1_data", bus.HRDATA, 32'hDEADBEEF);
    chk("r1_ready_d", 32'(bus.HREADYOUT), 32'h1);
    chk("r1_resp", 32'(bus.HRESP), 32'h0); step;

    // Byte write to lane 3
    wr_a(32'h13, HSIZE_BYTE, 32'h0); step;
    idle(32'h55000000); at_mid;
    chk("b_we", 32'(bram_we), 32'h8);
    chk("b_lane3", 32'(bram_wdata[31:24]), 32'h55); step;
    rd_a(32'h10, 32'h0); step;
    idle(32'h0); at_mid;
    chk("b_rdata", bus.HRDATA, 32'h55ADBEEF); step;

    // Write buffered behind back-to-back reads, forwarded, then committed
    wr_a(32'h20, HSIZE_WORD, 32'h0); step;
    rd_a(32'h20, 32'h11223344); at_mid;
    chk("fw_no_direct", 32'(bram_we), 32'h0);
    chk("fw_rd_addr", 32'(bram_addr), 32'h8); step;
    rd_a(32'h20, 32'h0); at_mid;
    chk("fw_buf_valid", 32'(dut.u_wbuf.r_buf_valid), 32'h1);
    chk("fw_rdata1", bus.HRDATA, 32'h11223344);
    chk("fw_hold_we", 32'(bram_we), 32'h0); step;
    idle(32'h0); at_mid;
    chk("fw_rdata2", bus.HRDATA, 32'h11223344);
    chk("fw_commit_we", 32'(bram_we), 32'hF);
    chk("fw_commit_addr", 32'(bram_addr), 32'h8);
    chk("fw_commit_data", bram_wdata, 32'h11223344); step;
    idle(32'h0); at_mid;
    chk("fw_buf_clear", 32'(dut.u_wbuf.r_buf_valid), 32'h0);
    chk("fw_after_we", 32'(bram_we), 32'h0); step;
    rd_a(32'h20, 32'h0); step;
    idle(32'h0); at_mid;
    chk("fw_ram", bus.HRDATA, 32'h11223344); step;

    // Partial-lane merge from the buffer
    wr_a(32'h21, HSIZE_BYTE, 32'h0); step;
    rd_a(32'h20, 32'h0000AA00); at_mid;
    chk("pm_no_direct", 32'(bram_we), 32'h0); step;
    idle(32'h0); at_mid;
    chk("pm_merge", bus.HRDATA, 32'h1122AA44);
    chk("pm_commit_we", 32'(bram_we), 32'h2); step;

    // Buffer held across four reads of other words
    wr_a(32'h30, HSIZE_WORD, 32'h0); step;
    rd_a(32'h10, 32'hCAFEF00D); at_mid;
    chk("h_no_direct", 32'(bram_we), 32'h0); step;
    rd_a(32'h20, 32'h0); at_mid;
    chk("h_rd1", bus.HRDATA, 32'h55ADBEEF);
    chk("h_buf1", 32'(dut.u_wbuf.r_buf_valid), 32'h1); step;
    rd_a(32'h14, 32'h0); at_mid;
    chk("h_rd2", bus.HRDATA, 32'h1122AA44);
    chk("h_buf2", 32'(dut.u_wbuf.r_buf_valid), 32'h1); step;
    rd_a(32'h24, 32'h0); at_mid;
    chk("h_rd3", bus.HRDATA, 32'h0);
    chk("h_buf3", 32'(dut.u_wbuf.r_buf_valid), 32'h1); step;
    idle(32'h0); at_mid;
    chk("h_rd4", bus.HRDATA, 32'h0);
    chk("h_commit_we", 32'(bram_we), 32'hF);
    chk("h_commit_addr", 32'(bram_addr), 32'hC);
    chk("h_commit_data", bram_wdata, 32'hCAFEF00D); step;
    rd_a(32'h30, 32'h0); step;
    idle(32'h0); at_mid;
    chk("h_ram", bus.HRDATA, 32'hCAFEF00D); step;

    // Misaligned word write
    wr_a(32'h42, HSIZE_WORD, 32'h0); at_mid;
    chk("e_aphase_ready", 32'(bus.HREADYOUT), 32'h1);
    chk("e_aphase_resp", 32'(bus.HRESP), 32'h0); step;
    idle(32'h12345678); at_mid;
`ifdef AHB_BRAM_ERR_EN
    chk("e_c1_ready", 32'(bus.HREADYOUT), 32'h0);
    chk("e_c1_resp", 32'(bus.HRESP), 32'h1);
    chk("e_c1_we", 32'(bram_we), 32'h0); step;
    idle(32'h0); at_mid;
    chk("e_c2_ready", 32'(bus.HREADYOUT), 32'h1);
    chk("e_c2_resp", 32'(bus.HRESP), 32'h1);
    chk("e_c2_we", 32'(bram_we), 32'h0); step;
`else
    chk("e_ok_ready", 32'(bus.HREADYOUT), 32'h1);
    chk("e_ok_resp", 32'(bus.HRESP), 32'h0);
    chk("e_ok_we", 32'(bram_we), 32'hF);
    chk("e_ok_addr", 32'(bram_addr), 32'h10); step;
    idle(32'h0); at_mid;
    chk("e_ok_resp2", 32'(bus.HRESP), 32'h0); step;
`endif
    idle(32'h0); at_mid;
    chk("e_end_ready", 32'(bus.HREADYOUT), 32'h1);
    chk("e_end_resp", 32'(bus.HRESP), 32'h0); step;
    rd_a(32'h40, 32'h0); step;
    idle(32'h0); at_mid;
`ifdef AHB_BRAM_ERR_EN
    chk("e_ram", bus.HRDATA, 32'h0); step;
`else
    chk("e_ram", bus.HRDATA, 32'h12345678); step;
`endif

    // Reset while the buffer is occupied
    wr_a(32'h50, HSIZE_WORD, 32'h0); step;
    rd_a(32'h54, 32'h77777777); step;
    rd_a(32'h58, 32'h0); at_mid;
    chk("rr_buf_before", 32'(dut.u_wbuf.r_buf_valid), 32'h1);
    HRESET = 1'b1;
    idle(32'h0);
    #1;
    chk("rr_buf_after", 32'(dut.u_wbuf.r_buf_valid), 32'h0);
    chk("rr_we", 32'(bram_we), 32'h0);
    chk("rr_ready", 32'(bus.HREADYOUT), 32'h1);
    chk("rr_resp", 32'(bus.HRESP), 32'h0);
    step;
    HRESET = 1'b0;
    at_mid;
    chk("rr_no_commit", 32'(bram_we), 32'h0);
    chk("rr_buf_idle", 32'(dut.u_wbuf.r_buf_valid), 32'h0); step;
    rd_a(32'h50, 32'h0); step;
    idle(32'h0); at_mid;
    chk("rr_ram", bus.HRDATA, 32'h0); step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
